// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the multiply/divide responder and the opcode control unit.
package mult_div_unit_pkg;

  // Default operand width and iteration counter width.
  localparam int unsigned MduWidth = 32;
  localparam int unsigned MduCntW  = 6;

  // FSM state encoding.
  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StMult = 3'd1;
  localparam logic [2:0] StDiv  = 3'd2;
  localparam logic [2:0] StFix  = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  // ControlType codes the control unit decodes into start_mult / start_div.
  localparam logic [4:0] CtrlMult = 5'b01010;
  localparam logic [4:0] CtrlDiv  = 5'b01001;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the control unit (master) and the mult/div unit (slave).
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = mult_div_unit_pkg::MduWidth
) ();

  logic             start_mult;
  logic             start_div;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             divby0flag;

  modport master (
    output start_mult, start_div, op_a, op_b,
    input  hi, lo, busy, done, divby0flag
  );

  modport slave (
    input  start_mult, start_div, op_a, op_b,
    output hi, lo, busy, done, divby0flag
  );

endinterface

// File: rtl/mult_div_unit_restoring_div_core.sv
// Unsigned restoring divider datapath: one quotient bit per step, MSB first.
module mult_div_unit_restoring_div_core #(
  parameter int unsigned WIDTH = mult_div_unit_pkg::MduWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             fits;

  // Trial subtract of the divisor from the shifted partial remainder, with a spare sign bit.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, dsr_q};
    fits    = ~trial[WIDTH+1];
  end

  // Next-state for the remainder/quotient shift registers.
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dsr_d = dsr_q;
    if (load_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dsr_d = divisor_i;
    end else if (step_i) begin
      // The dividend drains out of quo_q's top as quotient bits enter at the bottom.
      if (fits) begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dsr_q <= dsr_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

  // A successful trial is always below the divisor, so this bit is zero whenever it is used.
  logic unused_trial;
  assign unused_trial = trial[WIDTH];

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) responder writing HI/LO.
module mult_div_unit #(
  parameter int unsigned WIDTH = mult_div_unit_pkg::MduWidth,
  parameter int unsigned CNT_W = mult_div_unit_pkg::MduCntW
) (
  input  logic          clk,
  input  logic          reset,
  mult_div_unit_if.slave bus_io
);

  import mult_div_unit_pkg::*;

  localparam int unsigned AccW = 2 * WIDTH + 1;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div0_q, div0_d;

  logic             accept_mult, accept_div, last_iter;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   booth_upper, booth_mcand, booth_sum;
  logic [AccW-1:0]  acc_step;
  logic             div_load, div_step;
  logic [WIDTH-1:0] div_quo, div_rem, quo_fix, rem_fix;

  // Start decode; mult has priority when both requests arrive together.
  always_comb begin
    accept_mult = (state_q == StIdle) && bus_io.start_mult;
    accept_div  = (state_q == StIdle) && bus_io.start_div && !bus_io.start_mult;
    last_iter   = (cnt_q == CNT_W'(WIDTH - 1));
    // Two's complement magnitude; the most negative value maps onto its unsigned bit pattern.
    mag_a = bus_io.op_a[WIDTH-1] ? (~bus_io.op_a + WIDTH'(1)) : bus_io.op_a;
    mag_b = bus_io.op_b[WIDTH-1] ? (~bus_io.op_b + WIDTH'(1)) : bus_io.op_b;
  end

  // One Booth iteration: add/sub on a sign-extended upper half, then arithmetic shift right.
  always_comb begin
    booth_upper = {acc_q[AccW-1], acc_q[AccW-1 -: WIDTH]};
    booth_mcand = {mcand_q[WIDTH-1], mcand_q};
    case (acc_q[1:0])
      2'b01:   booth_sum = booth_upper + booth_mcand;
      2'b10:   booth_sum = booth_upper - booth_mcand;
      default: booth_sum = booth_upper;
    endcase
    acc_step = {booth_sum, acc_q[WIDTH:1]};
  end

  // Sign correction of the unsigned divide result (truncation toward zero).
  always_comb begin
    quo_fix = (neg_a_q ^ neg_b_q) ? ('0 - div_quo) : div_quo;
    rem_fix = neg_a_q ? ('0 - div_rem) : div_rem;
  end

  // FSM next-state, operand capture and HI/LO update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    div0_d   = 1'b0;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept_mult) begin
          state_d = StMult;
          cnt_d   = '0;
          acc_d   = {{WIDTH{1'b0}}, bus_io.op_b, 1'b0};
          mcand_d = bus_io.op_a;
        end else if (accept_div) begin
          if (bus_io.op_b == '0) begin
            // Abort straight to DONE; HI/LO keep the previous result.
            state_d = StDone;
            div0_d  = 1'b1;
          end else begin
            state_d  = StDiv;
            cnt_d    = '0;
            neg_a_d  = bus_io.op_a[WIDTH-1];
            neg_b_d  = bus_io.op_b[WIDTH-1];
            div_load = 1'b1;
          end
        end
      end
      StMult: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d = StDone;
          hi_d    = acc_step[AccW-1 -: WIDTH];
          lo_d    = acc_step[WIDTH:1];
        end
      end
      StDiv: begin
        div_step = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d = StDone;
        lo_d    = quo_fix;
        hi_d    = rem_fix;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div0_q  <= div0_d;
    end
  end

  mult_div_unit_restoring_div_core #(
    .WIDTH (WIDTH)
  ) u_div_core (
    .clk         (clk),
    .reset       (reset),
    .load_i      (div_load),
    .step_i      (div_step),
    .dividend_i  (mag_a),
    .divisor_i   (mag_b),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  assign bus_io.hi         = hi_q;
  assign bus_io.lo         = lo_q;
  assign bus_io.busy       = (state_q == StMult) || (state_q == StDiv) || (state_q == StFix);
  assign bus_io.done       = (state_q == StDone);
  assign bus_io.divby0flag = div0_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: cycle-level reference model plus directed vectors.
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference arithmetic straight from the signed definitions.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  // Returns {remainder, quotient}; the one overflowing case wraps.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    sa = $signed(a);
    sb = $signed(b);
    if (sa == int'(32'h8000_0000) && sb == -1) begin
      q = sa;
      r = 0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return {r, q};
  endfunction

  // Transaction-level model: countdown to done, pending result, visible HI/LO.
  logic        m_valid   = 1'b0;
  int          busy_left = 0;
  logic [31:0] e_hi = '0, e_lo = '0, p_hi = '0, p_lo = '0;
  logic        e_done = 1'b0, e_div0 = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_valid   <= 1'b1;
      busy_left <= 0;
      e_hi      <= '0;
      e_lo      <= '0;
      e_done    <= 1'b0;
      e_div0    <= 1'b0;
    end else begin
      e_done <= 1'b0;
      e_div0 <= 1'b0;
      if (busy_left > 0) begin
        busy_left <= busy_left - 1;
        if (busy_left == 1) begin
          e_done <= 1'b1;
          e_hi   <= p_hi;
          e_lo   <= p_lo;
        end
      end else if (!e_done) begin
        if (bus.start_mult) begin
          {p_hi, p_lo} <= ref_mul(bus.op_a, bus.op_b);
          busy_left    <= 32;
        end else if (bus.start_div) begin
          if (bus.op_b == 32'd0) begin
            e_done <= 1'b1;
            e_div0 <= 1'b1;
          end else begin
            {p_hi, p_lo} <= ref_div(bus.op_a, bus.op_b);
            busy_left    <= 33;
          end
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model busy", 32'(bus.busy), 32'(busy_left > 0));
      check("model done", 32'(bus.done), 32'(e_done));
      check("model divby0flag", 32'(bus.divby0flag), 32'(e_div0));
      check("model hi", bus.hi, e_hi);
      check("model lo", bus.lo, e_lo);
    end
  end

  // Issue one request at a negedge, wait for done, check latency and literal results.
  task automatic do_op(input string name, input logic sm, input logic sd,
                       input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                       input logic [31:0] xhi, input logic [31:0] xlo, input logic xdiv0);
    int   lat;
    logic saw_busy;
    bus.start_mult = sm;
    bus.start_div  = sd;
    bus.op_a       = a;
    bus.op_b       = b;
    @(negedge clk);
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.op_a       = $urandom;
    bus.op_b       = $urandom;
    lat      = 1;
    saw_busy = bus.busy;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " hi"}, bus.hi, xhi);
    check({name, " lo"}, bus.lo, xlo);
    check({name, " divby0flag"}, 32'(bus.divby0flag), 32'(xdiv0));
    check({name, " busy after start"}, 32'(saw_busy), 32'(!xdiv0));
    @(negedge clk);
    check({name, " done one cycle"}, 32'(bus.done), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int extra_done;
    reset          = 1'b1;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.op_a       = '0;
    bus.op_b       = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset hi", bus.hi, 32'h0);
    check("reset lo", bus.lo, 32'h0);
    check("reset busy", 32'(bus.busy), 32'(0));
    check("reset done", 32'(bus.done), 32'(0));
    check("reset divby0flag", 32'(bus.divby0flag), 32'(0));
    @(negedge clk);

    do_op("mult 7*-3", 1, 0, 32'd7, 32'hFFFF_FFFD, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    do_op("mult min*min", 1, 0, 32'h8000_0000, 32'h8000_0000, 33,
          32'h4000_0000, 32'h0000_0000, 0);
    do_op("mult max*min", 1, 0, 32'h7FFF_FFFF, 32'h8000_0000, 33,
          32'hC000_0000, 32'h8000_0000, 0);
    do_op("div -7/2", 0, 1, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    do_op("div 7/-2", 0, 1, 32'd7, 32'hFFFF_FFFE, 34, 32'h0000_0001, 32'hFFFF_FFFD, 0);
    do_op("div by zero", 0, 1, 32'd5, 32'd0, 1, 32'h0000_0001, 32'hFFFF_FFFD, 1);
    do_op("div -100/7", 0, 1, 32'hFFFF_FF9C, 32'd7, 34, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 0);
    do_op("div min/-1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 34,
          32'h0000_0000, 32'h8000_0000, 0);
    do_op("both starts", 1, 1, 32'd3, 32'd5, 33, 32'h0, 32'h0000_000F, 0);

    // A div request arriving in cycle 10 of a running mult must be ignored.
    bus.start_mult = 1'b1;
    bus.op_a       = 32'h0001_2345;
    bus.op_b       = 32'h0000_0010;
    @(negedge clk);
    bus.start_mult = 1'b0;
    lat = 1;
    repeat (9) begin
      @(negedge clk);
      lat++;
    end
    bus.start_div = 1'b1;
    bus.op_a      = 32'd100;
    bus.op_b      = 32'd3;
    @(negedge clk);
    lat++;
    bus.start_div = 1'b0;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("collision latency", 32'(lat), 32'(33));
    check("collision hi", bus.hi, 32'h0);
    check("collision lo", bus.lo, 32'h0012_3450);
    extra_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) extra_done++;
    end
    check("collision no second done", 32'(extra_done), 32'(0));

    // Reset in cycle 15 of a divide discards it and clears HI/LO.
    bus.start_div = 1'b1;
    bus.op_a      = 32'd1000;
    bus.op_b      = 32'd7;
    @(negedge clk);
    bus.start_div = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid reset busy", 32'(bus.busy), 32'(0));
    check("mid reset hi", bus.hi, 32'h0);
    check("mid reset lo", bus.lo, 32'h0);
    check("mid reset done", 32'(bus.done), 32'(0));
    extra_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done) extra_done++;
    end
    check("mid reset no done", 32'(extra_done), 32'(0));

    do_op("mult 6*7", 1, 0, 32'd6, 32'd7, 33, 32'h0, 32'd42, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
